n2r_buffer_v3: RTL and testbench

N2R_BUFFER_V3 -- requirements
Module: n2r_buffer_v3

---
 rtl/n2r_buffer_v3.sv | 213 +++++++++++++++++++++
 tb/tb_n2r_buffer_v3.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n2r_buffer_v3.sv
// Row-to-block reorder buffer: stores a frame of rows, then emits column-block beats per slice of rows.
// Latency: out_valid rises SLICE_ROWS+2 cycles after each LOAD entry; one beat per accepted handshake.
// Backpressure: in_ready only in FILL; out_data/out_valid held while out_ready is low.
module n2r_buffer_v3 #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 8,
  parameter int ROW        = 2754,
  parameter int COL        = 256
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              flush,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [WIDTH*COL-1:0]                              in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0]  out_data,
  output logic                                              slice_done,
  output logic                                              frame_done,
  output logic                                              busy
);

  localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
  localparam int NBEATS     = COL / BLOCK_SIZE;
  localparam int NSLICES    = (ROW + SLICE_ROWS - 1) / SLICE_ROWS;
  localparam int ROW_BITS   = WIDTH * COL;
  localparam int OUT_W      = WIDTH * BLOCK_SIZE * SLICE_ROWS;
  localparam int ROW_W      = $clog2((ROW > 2) ? ROW : 2);
  localparam int LD_W       = $clog2((SLICE_ROWS + 1 > 2) ? SLICE_ROWS + 1 : 2);
  localparam int IDX_W      = $clog2((SLICE_ROWS > 2) ? SLICE_ROWS : 2);
  localparam int BEAT_W     = $clog2((NBEATS > 2) ? NBEATS : 2);
  localparam int SLC_W      = $clog2((NSLICES > 2) ? NSLICES : 2);

  // A row cannot be split into whole blocks otherwise.
  generate
    if (COL % BLOCK_SIZE != 0) begin : g_bad_col
      $error("COL must be a multiple of BLOCK_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_LOAD, S_DRAIN} state_t;

  state_t              r_state;
  logic                r_in_rdy;
  logic                r_out_vld;
  logic [OUT_W-1:0]    r_out_dat;
  logic [ROW_W-1:0]    r_wr_cnt;
  logic [LD_W-1:0]     r_ld_cnt;
  logic                r_rd_pend;
  logic [IDX_W-1:0]    r_rd_idx;
  logic                r_rd_zero;
  logic [SLC_W-1:0]    r_slc_idx;
  logic [BEAT_W-1:0]   r_beat;

  logic [ROW_BITS-1:0] r_mem [ROW];
  logic [ROW_BITS-1:0] r_ram_q;
  logic [ROW_BITS-1:0] r_slc [SLICE_ROWS];

  logic                w_wr_en;
  logic                w_xfer;
  logic                w_last_beat;
  logic                w_last_slc;
  int                  w_rd_row;
  logic                w_rd_oob;
  logic [ROW_W-1:0]    w_rd_addr;
  int                  w_sel;
  logic [OUT_W-1:0]    w_beat;

  assign w_wr_en     = in_valid && r_in_rdy && !flush;
  assign w_xfer      = r_out_vld && out_ready && (r_state == S_DRAIN);
  assign w_last_beat = (r_beat == BEAT_W'(NBEATS - 1));
  assign w_last_slc  = (r_slc_idx == SLC_W'(NSLICES - 1));

  // Frame row addressed by the current LOAD step; rows past the frame end read as zero.
  always_comb begin
    w_rd_row  = int'(r_slc_idx) * SLICE_ROWS + int'(r_ld_cnt);
    w_rd_oob  = (w_rd_row >= ROW);
    w_rd_addr = w_rd_oob ? '0 : ROW_W'(w_rd_row);
  end

  // Row RAM write port: accepted row k lands at address k.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_cnt] <= in_data;
    end
  end

  // Row RAM read port with one cycle of latency.
  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[w_rd_addr];
  end

  // Slice register captures the RAM word requested one cycle earlier.
  always_ff @(posedge clk) begin
    if (r_rd_pend) begin
      r_slc[r_rd_idx] <= r_rd_zero ? '0 : r_ram_q;
    end
  end

  // Beat builder: beat 0 while loading, otherwise the beat after the one on the output.
  always_comb begin
    w_beat = '0;
    w_sel  = (r_state == S_DRAIN) ? int'(r_beat) + 1 : 0;
    if (w_sel >= NBEATS) begin
      w_sel = 0;
    end
    for (int r = 0; r < SLICE_ROWS; r++) begin
      for (int b = 0; b < BLOCK_SIZE; b++) begin
        w_beat[OUT_W - 1 - (r * BLOCK_SIZE + b) * WIDTH -: WIDTH] =
          r_slc[r][ROW_BITS - 1 - (w_sel * BLOCK_SIZE + b) * WIDTH -: WIDTH];
      end
    end
  end

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_wr_cnt  <= '0;
      r_ld_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_zero <= 1'b0;
      r_slc_idx <= '0;
      r_beat    <= '0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_wr_cnt  <= '0;
      r_ld_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_zero <= 1'b0;
      r_slc_idx <= '0;
      r_beat    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FILL;
            r_in_rdy <= 1'b1;
            r_wr_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_wr_en) begin
            if (r_wr_cnt == ROW_W'(ROW - 1)) begin
              r_state   <= S_LOAD;
              r_in_rdy  <= 1'b0;
              r_wr_cnt  <= '0;
              r_ld_cnt  <= '0;
              r_slc_idx <= '0;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_rd_pend <= 1'b0;
          if (r_ld_cnt < LD_W'(SLICE_ROWS)) begin
            r_rd_pend <= 1'b1;
            r_rd_idx  <= IDX_W'(r_ld_cnt);
            r_rd_zero <= w_rd_oob;
            r_ld_cnt  <= r_ld_cnt + 1'b1;
          end else if (!r_rd_pend) begin
            r_out_dat <= w_beat;
            r_out_vld <= 1'b1;
            r_beat    <= '0;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (w_last_beat) begin
              r_out_vld <= 1'b0;
              r_beat    <= '0;
              r_ld_cnt  <= '0;
              if (w_last_slc) begin
                r_state   <= S_IDLE;
                r_slc_idx <= '0;
              end else begin
                r_state   <= S_LOAD;
                r_slc_idx <= r_slc_idx + 1'b1;
              end
            end else begin
              r_beat    <= r_beat + 1'b1;
              r_out_dat <= w_beat;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_rdy;
  assign out_valid  = r_out_vld;
  assign out_data   = r_out_dat;
  assign busy       = (r_state != S_IDLE);
  assign slice_done = w_xfer && w_last_beat && !flush;
  assign frame_done = slice_done && w_last_slc;

endmodule

// File: tb/tb_n2r_buffer_v3.sv
// Bench for n2r_buffer_v3: directed frames against a queue-based reorder model.
// Covers basic frame, padding, backpressure, input gaps, flush with start, async reset mid-fill.
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_n2r_buffer_v3;

  localparam int WIDTH = 16;
  localparam int BS    = 2;
  localparam int NC    = 2;
  localparam int ROWP  = 6;
  localparam int COLP  = 4;
  localparam int SR    = BS * NC;
  localparam int NB    = COLP / BS;
  localparam int NS    = (ROWP + SR - 1) / SR;
  localparam int OW    = WIDTH * BS * SR;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH*COLP-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              slice_done;
  logic              frame_done;
  logic              busy;

  always #5 clk = ~clk;

  n2r_buffer_v3 #(
    .WIDTH(WIDTH), .BLOCK_SIZE(BS), .NUM_CORES(NC), .ROW(ROWP), .COL(COLP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .slice_done(slice_done), .frame_done(frame_done), .busy(busy)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          sd;
    logic          fd;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            n_writes = 0;
  int            n_xfer = 0;
  logic [OW-1:0] beat_log [4];
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  int            hold = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] elem(input int off, input int r, input int c);
    return 16'(off + 16 * r + c);
  endfunction

  function automatic logic [WIDTH*COLP-1:0] row_data(input int off, input int k);
    logic [WIDTH*COLP-1:0] d = '0;
    for (int j = 0; j < COLP; j++) d = {d[WIDTH*(COLP-1)-1:0], elem(off, k, j)};
    return d;
  endfunction

  // Reference beat: rows of the slice top to bottom, block columns left to right, zero past frame end.
  function automatic logic [OW-1:0] exp_beat(input int off, input int s, input int c);
    logic [OW-1:0] d = '0;
    logic [15:0]   v;
    for (int r = 0; r < SR; r++) begin
      for (int b = 0; b < BS; b++) begin
        v = (s * SR + r < ROWP) ? elem(off, s * SR + r, c * BS + b) : 16'h0;
        d = {d[OW-WIDTH-1:0], v};
      end
    end
    return d;
  endfunction

  task automatic push_frame(input int off);
    exp_t e;
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < NB; c++) begin
        e.d  = exp_beat(off, s, c);
        e.sd = (c == NB - 1);
        e.fd = (c == NB - 1) && (s == NS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Per-cycle output checker against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (flush) begin
        chk("flush_no_slice_done", {127'b0, slice_done}, '0);
        chk("flush_no_frame_done", {127'b0, frame_done}, '0);
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", {127'b0, out_valid}, 1);
          chk("stall_data_held", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {127'b0, out_valid}, '0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_slice_done", {127'b0, slice_done}, {127'b0, e.sd});
            chk("beat_frame_done", {127'b0, frame_done}, {127'b0, e.fd});
          end
          if (n_xfer < 4) beat_log[n_xfer] = out_data;
          n_xfer++;
        end else begin
          chk("idle_pulses_low", {126'b0, slice_done, frame_done}, '0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
      if (in_valid && in_ready) n_writes++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int off, input int nrows, input bit gaps, input bit hold_valid);
    int k = 0;
    int cyc = 0;
    bit ph = 1'b1;
    bit hs;
    while (k < nrows && cyc < 100) begin
      in_valid = gaps ? ph : 1'b1;
      in_data  = in_valid ? row_data(off, k) : {(WIDTH*COLP/16){16'hdead}};
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      ph = ~ph;
      cyc++;
    end
    if (k < nrows) chk("feed_timeout", k, nrows);
    in_valid = hold_valid;
    in_data  = {(WIDTH*COLP/16){16'hbeef}};
  endtask

  task automatic drain(input int mode);
    bit done = 1'b0;
    bit pulsed = 1'b0;
    int cyc = 0;
    hold = 0;
    out_ready = 1'b1;
    while (!done && cyc < 200) begin
      if (mode == 2 && out_valid && n_xfer == 1) begin
        flush = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_busy", {127'b0, busy}, '0);
        chk("flush_out_valid", {127'b0, out_valid}, '0);
        chk("flush_in_ready", {127'b0, in_ready}, '0);
        @(posedge clk); #1;
        chk("flush_start_ignored", {127'b0, busy}, '0);
        return;
      end
      if (mode == 1 && out_valid && n_xfer == 1 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      start = (mode == 0 && n_xfer == 1 && !pulsed);
      if (start) pulsed = 1'b1;
      @(negedge clk);
      if (frame_done) done = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("drain_done", {127'b0, done}, 1);
    chk("idle_after_frame", {127'b0, busy}, '0);
    chk("beats_per_frame", n_xfer, NS * NB);
    chk("model_queue_empty", exp_q.size(), 0);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int off, input bit gaps, input int mode, input bit hold_valid);
    n_writes = 0;
    n_xfer = 0;
    push_frame(off);
    pulse_start();
    chk("in_ready_in_fill", {127'b0, in_ready}, 1);
    feed(off, ROWP, gaps, hold_valid);
    chk("in_ready_low_after_last", {127'b0, in_ready}, '0);
    drain(mode);
    chk("row_writes", n_writes, ROWP);
  endtask

  // Hand-computed beats for element(r,c)=16*r+c.
  task automatic check_lits();
    logic [OW-1:0] l0 = 128'h0000_0001_0010_0011_0020_0021_0030_0031;
    logic [OW-1:0] l1 = 128'h0002_0003_0012_0013_0022_0023_0032_0033;
    logic [OW-1:0] l2 = 128'h0040_0041_0050_0051_0000_0000_0000_0000;
    logic [OW-1:0] l3 = 128'h0042_0043_0052_0053_0000_0000_0000_0000;
    chk("lit_beat0", beat_log[0], l0);
    chk("lit_beat1", beat_log[1], l1);
    chk("lit_pad_beat2", beat_log[2], l2);
    chk("lit_pad_beat3", beat_log[3], l3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'b0, in_ready}, '0);
    chk("rst_out_valid", {127'b0, out_valid}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", {127'b0, busy}, '0);
    chk("rst_pulses", {126'b0, slice_done, frame_done}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {127'b0, busy}, '0);

    run_frame(0, 1'b0, 0, 1'b1);
    check_lits();

    run_frame(256, 1'b0, 1, 1'b0);
    chk("backpressure_cycles", hold, 5);

    run_frame(0, 1'b1, 0, 1'b0);
    check_lits();

    n_writes = 0;
    n_xfer = 0;
    push_frame(512);
    pulse_start();
    feed(512, ROWP, 1'b0, 1'b0);
    drain(2);
    chk("flushed_frame_beats", n_xfer, 1);

    run_frame(0, 1'b0, 0, 1'b0);
    check_lits();

    n_writes = 0;
    pulse_start();
    feed(768, 3, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {127'b0, in_ready}, '0);
    chk("async_rst_busy", {127'b0, busy}, '0);
    chk("async_rst_out_valid", {127'b0, out_valid}, '0);
    chk("async_rst_out_data", out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_data = row_data(768, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_in_ready", {127'b0, in_ready}, '0);
    chk("post_rst_busy", {127'b0, busy}, '0);
    in_valid = 1'b0;

    run_frame(768, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
